// File: rtl/flash_sample_fetcher.sv
// flash_sample_fetcher: fetches 32-bit flash words over Avalon-MM and emits two 16-bit samples per word, one per sample tick
// clk, rst                 clock, synchronous active-high reset
// pause, forward           hold playback / ascending (1) or descending (0) addresses
// fetcher_reset            1-cycle pulse restarting the song from its start
// sample_freq_div          clk cycles per sample period (values below 2 act as 2)
// flash_*                  Avalon-MM read master (address, read, waitrequest, readdata, readdatavalid)
// sample_out, sample_valid current sample and its 1-cycle update strobe
module flash_sample_fetcher #(
  parameter int ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR = 23'h7FFFF,
  parameter int FREQ_DIV_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pause,
  input  logic                      forward,
  input  logic                      fetcher_reset,
  input  logic [FREQ_DIV_WIDTH-1:0] sample_freq_div,
  output logic [ADDR_WIDTH-1:0]     flash_address,
  output logic                      flash_read,
  input  logic                      flash_waitrequest,
  input  logic [31:0]               flash_readdata,
  input  logic                      flash_readdatavalid,
  output logic [15:0]               sample_out,
  output logic                      sample_valid
);
  typedef enum logic [1:0] {REQ, WAIT, HALF0, HALF1} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, step_addr;
  logic [FREQ_DIV_WIDTH-1:0] cnt_q, cnt_d, eff_div;
  logic [31:0] word_q, word_d;
  logic [15:0] sample_q, sample_d;
  logic dir_q, dir_d, pend_q, pend_d, discard_q, discard_d, valid_q, valid_d;
  logic tick, emit, fetching, got;
  always_comb begin
    eff_div = sample_freq_div < FREQ_DIV_WIDTH'(2) ? FREQ_DIV_WIDTH'(2) : sample_freq_div;
    tick = !pause && cnt_q >= eff_div - FREQ_DIV_WIDTH'(1);
    fetching = state_q == REQ || state_q == WAIT;
    got = state_q == WAIT && flash_readdatavalid;
    // fetcher_reset outranks both a fresh tick and a held pend
    emit = !fetching && (tick || pend_q) && !fetcher_reset;
    step_addr = dir_q ? (addr_q == MAX_ADDR ? '0 : addr_q + ADDR_WIDTH'(1))
                      : (addr_q == '0 ? MAX_ADDR : addr_q - ADDR_WIDTH'(1));
    cnt_d = fetcher_reset || tick ? '0 : pause ? cnt_q : cnt_q + FREQ_DIV_WIDTH'(1);
    pend_d = fetcher_reset || emit ? 1'b0 : fetching && tick ? 1'b1 : pend_q;
    // a read already issued must still complete; its word is dropped on return
    discard_d = got ? 1'b0 : fetcher_reset && fetching ? 1'b1 : discard_q;
    word_d = got ? flash_readdata : word_q;
    dir_d = got ? forward : dir_q;
    addr_d = fetcher_reset ? (forward ? '0 : MAX_ADDR) : state_q == HALF1 && emit ? step_addr : addr_q;
    sample_d = emit ? ((dir_q == (state_q == HALF0)) ? word_q[15:0] : word_q[31:16]) : sample_q;
    valid_d = emit;
    state_d = state_q;
    case (state_q)
      REQ:     state_d = flash_waitrequest ? REQ : WAIT;
      WAIT:    state_d = !flash_readdatavalid ? WAIT : discard_q || fetcher_reset ? REQ : HALF0;
      HALF0:   state_d = fetcher_reset ? REQ : emit ? HALF1 : HALF0;
      default: state_d = fetcher_reset || emit ? REQ : HALF1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      addr_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      sample_q <= '0;
      dir_q <= 1'b0;
      pend_q <= 1'b0;
      discard_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      sample_q <= sample_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      discard_q <= discard_d;
      valid_q <= valid_d;
    end
  end
  assign flash_read = state_q == REQ && !rst;
  assign flash_address = addr_q;
  assign sample_out = sample_q;
  assign sample_valid = valid_q;
endmodule
